writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage. Takes retiring instructions from the memory stage, waits for data-memory load responses, selects and extends load data, and drives the register bank write port (RegWrite, write_register, write_data).
- Exposes the pending load destination so decode can stall on read-after-write hazards against rs1 (instruction[19:15]) and rs2 (instruction[24:20]).

Parameters:
- XLEN, 32, datapath width; load extension logic is defined for 32 only.
- REG_ADDR_W, 5, register index width (rd = instruction[11:7]).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  unit accepts the instruction this cycle
- in_instruction  input  32  instruction word; rd=[11:7], funct3=[14:12]
- in_alu_result  input  XLEN  ALU result, or load address for loads
- in_mem_to_reg  input  1  1 = load, write memory data; 0 = write ALU result
- in_reg_write  input  1  instruction writes rd
- mem_rsp_valid  input  1  data memory read response valid (one-cycle pulse)
- mem_rsp_data  input  XLEN  aligned 32-bit word from memory
- RegWrite  output  1  register bank write enable, one cycle per write
- write_register  output  REG_ADDR_W  destination index
- write_data  output  XLEN  value to write (MemtoReg mux output)
- load_pending  output  1  a load is waiting for its response
- pending_rd  output  REG_ADDR_W  rd of the pending load; 0 when none pending
- stray_rsp  output  1  sticky: a response arrived with no load pending
- retired_count  output  CNT_W  count of completed instructions; wraps

Behaviour:
- Reset values: in_ready=0 while rst is asserted, then 1. RegWrite=0, write_register=0, write_data=0, load_pending=0, pending_rd=0, stray_rsp=0, retired_count=0, state=IDLE.
- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
- Accept occurs when in_valid && in_ready.
- Non-load accept (in_mem_to_reg=0):
  - Next cycle: RegWrite = in_reg_write && (rd!=0), write_register=rd, write_data=in_alu_result.
  - State stays IDLE, so back-to-back accepts are possible every cycle.
- Load accept (in_mem_to_reg=1):
  - Latch rd, funct3 and offset (in_alu_result[1:0]).
  - Latch a write flag = in_reg_write && rd!=0.
  - Go to WAIT_MEM. load_pending=1 and pending_rd=rd from the next cycle.
- WAIT_MEM:
  - Hold until mem_rsp_valid.
  - On the response cycle, register the extended data. RegWrite pulses the next cycle only if the write flag is set.
  - Return to IDLE that same next cycle; load_pending and pending_rd clear with it.
  - There is no timeout.
- Load extension (offset o):
  - 000 LB: sign-extend byte o.
  - 001 LH: sign-extend halfword o[1]; o[0] ignored.
  - 010 LW: full word; o ignored.
  - 100 LBU: zero-extend byte o.
  - 101 LHU: zero-extend halfword o[1].
  - 011, 110, 111: treated as LW.
- When RegWrite is 0, write_register and write_data hold their last values.
- Writes to x0 are never issued. Loads to x0, or loads with in_reg_write=0, still wait for their response.
- mem_rsp_valid in IDLE, including the same cycle a load is accepted, sets stray_rsp. The response is otherwise ignored.
- retired_count increments by 1 per completed instruction, whether or not it writes:
  - non-load: on the accept cycle;
  - load: on the response cycle.
  - It wraps from 2^CNT_W-1 to 0.
- Reset mid-load: the pending load is dropped and no write occurs. A response arriving after reset sets stray_rsp.
- Latency: accept to RegWrite is 1 cycle for non-loads; response to RegWrite is 1 cycle for loads.

Test Plan:
- ALU back-to-back: accept addi rd=5 (0x0A), then rd=6 (0x14) on consecutive cycles -> RegWrite high two consecutive cycles with (5,0x0A) then (6,0x14); retired_count=2.
- x0 suppression: accept ALU write rd=0 with result 0xFFFFFFFF -> RegWrite stays 0; retired_count increments.
- LB sign-extend: load rd=7, funct3=000, address 0x1003, then response 0x80000000 three cycles later -> load_pending=1 and pending_rd=7 during the wait; in_ready=0; write_data=0xFFFFFF80 to reg 7 one cycle after the response.
- LHU/LH: response 0x8001_1234 with address offset 2 -> LHU writes 0x00008001; LH writes 0xFFFF8001. Offset 0 LH writes 0x00001234.
- Stray and reset: mem_rsp_valid pulse in IDLE -> stray_rsp=1 and remains 1; assert rst during WAIT_MEM -> no RegWrite, all outputs at reset values, stray_rsp=0.
- Counter wrap: with CNT_W=4, retire 17 instructions -> retired_count=1.

Source files
------------

// File: rtl/writeback_unit.sv
// Final pipeline stage: retires ALU results directly, waits for load responses, extends load
// data and drives the register-bank write port; exposes the pending load rd for hazard stalls.
module writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instruction,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [XLEN-1:0]       write_data,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] pending_rd,
  output logic                  stray_rsp,
  output logic [CNT_W-1:0]      retired_count
);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e                  state_q;
  logic                    reg_write_q;
  logic [REG_ADDR_W-1:0]   write_register_q;
  logic [XLEN-1:0]         write_data_q;
  logic                    load_pending_q;
  logic [REG_ADDR_W-1:0]   pending_rd_q;
  logic                    stray_rsp_q;
  logic [CNT_W-1:0]        retired_q;
  logic [2:0]              ld_funct3_q;
  logic [1:0]              ld_offset_q;
  logic                    ld_wflag_q;

  logic [REG_ADDR_W-1:0]   in_rd;
  logic                    in_wflag;
  logic                    accept;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [XLEN-1:0]         ld_ext;

  assign in_rd    = in_instruction[7 +: REG_ADDR_W];
  assign in_wflag = in_reg_write && (in_rd != '0);
  assign in_ready = !rst && (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  // Offset selects the byte/halfword lane inside the aligned response word.
  always_comb begin
    ld_byte = mem_rsp_data[{ld_offset_q, 3'b000} +: 8];
    ld_half = ld_offset_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    unique case (ld_funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      load_pending_q   <= 1'b0;
      pending_rd_q     <= '0;
      stray_rsp_q      <= 1'b0;
      retired_q        <= '0;
      ld_funct3_q      <= '0;
      ld_offset_q      <= '0;
      ld_wflag_q       <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_rsp_valid) begin
            stray_rsp_q <= 1'b1;
          end
          if (accept) begin
            if (in_mem_to_reg) begin
              ld_funct3_q    <= in_instruction[14:12];
              ld_offset_q    <= in_alu_result[1:0];
              ld_wflag_q     <= in_wflag;
              pending_rd_q   <= in_rd;
              load_pending_q <= 1'b1;
              state_q        <= StWaitMem;
            end else begin
              retired_q <= retired_q + CNT_W'(1);
              if (in_wflag) begin
                reg_write_q      <= 1'b1;
                write_register_q <= in_rd;
                write_data_q     <= in_alu_result;
              end
            end
          end
        end
        StWaitMem: begin
          if (mem_rsp_valid) begin
            retired_q      <= retired_q + CNT_W'(1);
            load_pending_q <= 1'b0;
            pending_rd_q   <= '0;
            state_q        <= StIdle;
            // Loads to x0 or without reg_write still retire but leave the write port untouched.
            if (ld_wflag_q) begin
              reg_write_q      <= 1'b1;
              write_register_q <= pending_rd_q;
              write_data_q     <= ld_ext;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign RegWrite       = reg_write_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign load_pending   = load_pending_q;
  assign pending_rd     = pending_rd_q;
  assign stray_rsp      = stray_rsp_q;
  assign retired_count  = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected register writes, a negedge
// monitor pops and compares them whenever RegWrite is presented.
module tb_writeback_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instruction;
  logic [XLEN-1:0]  in_alu_result;
  logic             in_mem_to_reg;
  logic             in_reg_write;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_data;
  logic             RegWrite;
  logic [RW-1:0]    write_register;
  logic [XLEN-1:0]  write_data;
  logic             load_pending;
  logic [RW-1:0]    pending_rd;
  logic             stray_rsp;
  logic [CNT_W-1:0] retired_count;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t              sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  writeback_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_alu_result  (in_alu_result),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_write   (in_reg_write),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .RegWrite       (RegWrite),
    .write_register (write_register),
    .write_data     (write_data),
    .load_pending   (load_pending),
    .pending_rd     (pending_rd),
    .stray_rsp      (stray_rsp),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=reg%0d/%h required=no write at %0t",
                 write_register, write_data, $time);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_reg", 32'(write_register), 32'(e.rd));
        chk("wr_data", write_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] res, input logic rw);
    in_valid       = 1'b1;
    in_instruction = {17'b0, 3'b000, rd, 7'b0010011};
    in_alu_result  = res;
    in_mem_to_reg  = 1'b0;
    in_reg_write   = rw;
    if (rw && rd != 0) sb_q.push_back('{rd: rd, data: res});
    step();
    in_valid = 1'b0;
    exp_cnt++;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                            input logic rw);
    in_valid       = 1'b1;
    in_instruction = {17'b0, f3, rd, 7'b0000011};
    in_alu_result  = addr;
    in_mem_to_reg  = 1'b1;
    in_reg_write   = rw;
    step();
    in_valid      = 1'b0;
    mem_rsp_valid = 1'b0;
    chk("ld_pending", 32'(load_pending), 32'd1);
    chk("ld_pending_rd", 32'(pending_rd), 32'(rd));
    chk("ld_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] exp, input logic [4:0] rd,
                         input logic wr, input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      chk("wait_pending", 32'(load_pending), 32'd1);
      chk("wait_in_ready", 32'(in_ready), 32'd0);
    end
    if (wr) sb_q.push_back('{rd: rd, data: exp});
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    step();
    mem_rsp_valid = 1'b0;
    exp_cnt++;
    chk("rsp_pending_clr", 32'(load_pending), 32'd0);
    chk("rsp_pending_rd_clr", 32'(pending_rd), 32'd0);
    chk("rsp_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_wreg"}, 32'(write_register), 32'd0);
    chk({tag, "_wdata"}, write_data, 32'd0);
    chk({tag, "_pending"}, 32'(load_pending), 32'd0);
    chk({tag, "_pending_rd"}, 32'(pending_rd), 32'd0);
    chk({tag, "_stray"}, 32'(stray_rsp), 32'd0);
    chk({tag, "_count"}, 32'(retired_count), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    exp_cnt = '0;
    sb_q.delete();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_alu_result = '0;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step();
    step();
    check_reset_outputs("init");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // ALU back-to-back
    issue_alu(5'd5, 32'h0000_000A, 1'b1);
    issue_alu(5'd6, 32'h0000_0014, 1'b1);
    chk("count_b2b", 32'(retired_count), 32'd2);

    // x0 suppression and reg_write=0
    issue_alu(5'd0, 32'hFFFF_FFFF, 1'b1);
    issue_alu(5'd9, 32'h1234_5678, 1'b0);
    step();
    chk("count_x0", 32'(retired_count), 32'(exp_cnt));
    chk("hold_wdata", write_data, 32'h0000_0014);

    // Loads
    issue_load(5'd7, 3'b000, 32'h0000_1003, 1'b1);
    respond(32'h8000_0000, 32'hFFFF_FF80, 5'd7, 1'b1, 2);
    issue_load(5'd8, 3'b101, 32'h0000_2002, 1'b1);
    respond(32'h8001_1234, 32'h0000_8001, 5'd8, 1'b1, 0);
    issue_load(5'd9, 3'b001, 32'h0000_2002, 1'b1);
    respond(32'h8001_1234, 32'hFFFF_8001, 5'd9, 1'b1, 1);
    issue_load(5'd10, 3'b001, 32'h0000_2000, 1'b1);
    respond(32'h8001_1234, 32'h0000_1234, 5'd10, 1'b1, 0);
    issue_load(5'd11, 3'b010, 32'h0000_2001, 1'b1);
    respond(32'h8001_1234, 32'h8001_1234, 5'd11, 1'b1, 0);
    issue_load(5'd12, 3'b100, 32'h0000_2001, 1'b1);
    respond(32'h8001_1234, 32'h0000_0012, 5'd12, 1'b1, 0);
    issue_load(5'd13, 3'b110, 32'h0000_2003, 1'b1);
    respond(32'h8001_1234, 32'h8001_1234, 5'd13, 1'b1, 0);
    issue_load(5'd14, 3'b000, 32'h0000_2000, 1'b1);
    respond(32'h0000_007F, 32'h0000_007F, 5'd14, 1'b1, 0);
    issue_load(5'd0, 3'b010, 32'h0000_2000, 1'b1);
    respond(32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 2);
    issue_load(5'd15, 3'b010, 32'h0000_2000, 1'b0);
    respond(32'hCAFE_F00D, 32'h0, 5'd15, 1'b0, 1);
    step();
    chk("count_loads", 32'(retired_count), 32'(exp_cnt));
    chk("no_stray_yet", 32'(stray_rsp), 32'd0);

    // Stray response in IDLE is sticky
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_set", 32'(stray_rsp), 32'd1);
    step(); step();
    chk("stray_sticky", 32'(stray_rsp), 32'd1);
    chk("stray_no_count", 32'(retired_count), 32'(exp_cnt));

    // Reset mid-load drops the load; late response is stray
    issue_load(5'd11, 3'b010, 32'h0000_3000, 1'b1);
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("midload");
    step();
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
    step();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_stray", 32'(stray_rsp), 32'd1);
    chk("late_rsp_pending", 32'(load_pending), 32'd0);
    chk("late_rsp_count", 32'(retired_count), 32'd0);

    // Response coincident with a load accept is stray; the load still waits
    do_reset();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2222_2222;
    issue_load(5'd13, 3'b010, 32'h0000_4000, 1'b1);
    chk("coincident_stray", 32'(stray_rsp), 32'd1);
    respond(32'h3333_3333, 32'h3333_3333, 5'd13, 1'b1, 1);

    // Counter wrap at 4 bits
    do_reset();
    for (int i = 0; i < 17; i++) issue_alu(5'(i % 32), 32'(i), 1'(i % 2));
    chk("count_wrap", 32'(retired_count), 32'd1);

    step(); step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
